// File: rtl/matmul_sequencer.sv
// Sequences one C = A x B multiply of N x N word matrices held in main memory,
// reading A and B one word per cycle and writing each finished C element back.
module matmul_sequencer #(
    parameter int                N      = 3,
    parameter int                ADDR_W = 17,
    parameter int                DATA_W = 32,
    parameter logic [ADDR_W-1:0] A_BASE = 17'h00200,
    parameter logic [ADDR_W-1:0] B_BASE = 17'h00300,
    parameter logic [ADDR_W-1:0] C_BASE = 17'h00100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_WR_C,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  i, j, k;
    logic [DATA_W-1:0] acc, a_reg;

    wire k_last = (k == LAST);
    wire j_last = (j == LAST);
    wire i_last = (i == LAST);

    function automatic logic [ADDR_W-1:0] elem_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [IDX_W-1:0]  row,
                                                    input logic [IDX_W-1:0]  col);
        logic [ADDR_W-1:0] idx;
        idx = ADDR_W'(row) * ADDR_W'(N) + ADDR_W'(col);
        return base + (idx << 2);
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            acc   <= '0;
            a_reg <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        i   <= '0;
                        j   <= '0;
                        k   <= '0;
                        acc <= '0;
                    end
                end
                S_RD_A: a_reg <= mem_rdata;
                S_RD_B: begin
                    // Product and sum both wrap at DATA_W bits.
                    acc <= acc + a_reg * mem_rdata;
                    if (!k_last) k <= k + 1'b1;
                end
                S_WR_C: begin
                    acc <= '0;
                    k   <= '0;
                    if (j_last) begin
                        j <= '0;
                        i <= i_last ? '0 : i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_RD_A;
            S_RD_A:  state_nxt = S_RD_B;
            S_RD_B:  state_nxt = k_last ? S_WR_C : S_RD_A;
            S_WR_C:  state_nxt = (i_last && j_last) ? S_DONE : S_RD_A;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // value held, which would otherwise infer a latch.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        // Gating with reset silences the reset cycle itself, so a run cut
        // short never issues a partial write.
        if (!reset) begin
            unique case (state)
                S_RD_A: begin
                    busy     = 1'b1;
                    mem_read = 1'b1;
                    mem_addr = elem_addr(A_BASE, i, k);
                end
                S_RD_B: begin
                    busy     = 1'b1;
                    mem_read = 1'b1;
                    mem_addr = elem_addr(B_BASE, k, j);
                end
                S_WR_C: begin
                    busy      = 1'b1;
                    mem_write = 1'b1;
                    mem_addr  = elem_addr(C_BASE, i, j);
                    mem_wdata = acc;
                end
                S_DONE:  done = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: a word-addressed memory model serves A and B,
// and each run's C writes, busy count and done timing are compared with hand results.
module tb_matmul_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, mem_read, mem_write;
    logic [16:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem [0:255];
    assign mem_rdata = mem[mem_addr[9:2]];

    always #5 clk = ~clk;

    matmul_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    typedef struct packed {
        logic [8:0][31:0] a;
        logic [8:0][31:0] b;
        logic [8:0][31:0] c;
    } vec_t;

    vec_t        vecs [4];
    int          total = 0;
    int          bad = 0;
    int          overlap = 0;
    logic [16:0] wr_addr [0:31];
    logic [31:0] wr_data [0:31];
    int          wr_cnt, done_at, busy_cnt;

    always @(negedge clk) if (mem_read && mem_write) overlap++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {11'd0, busy, done, mem_read, mem_write, mem_addr, mem_wdata};
    endfunction

    task automatic load(input int v);
        for (int n = 0; n < 256; n++) mem[n] = 32'h0;
        for (int n = 0; n < 9; n++) begin
            mem[8'h80 + n] = vecs[v].a[n];
            mem[8'hC0 + n] = vecs[v].b[n];
        end
    endtask

    // Caller is at a negedge; cycle 1 is the first cycle after the accept edge.
    task automatic run_vec(input int v, input bit poke);
        load(v);
        wr_cnt = 0; done_at = 0; busy_cnt = 0;
        for (int n = 0; n < 32; n++) begin
            wr_addr[n] = '0;
            wr_data[n] = '0;
        end
        start = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            start = poke && (n == 10 || n == 40);
            if (busy) busy_cnt++;
            if (mem_write) begin
                if (wr_cnt < 32) begin
                    wr_addr[wr_cnt] = mem_addr;
                    wr_data[wr_cnt] = mem_wdata;
                end
                wr_cnt++;
            end
            if (done) begin
                done_at = n;
                break;
            end
        end
        start = 1'b0;
        check($sformatf("v%0d done_cycle", v), 64'(done_at), 64'd64);
        check($sformatf("v%0d busy_cycles", v), 64'(busy_cnt), 64'd63);
        check($sformatf("v%0d write_count", v), 64'(wr_cnt), 64'd9);
        for (int w = 0; w < 9; w++)
            check($sformatf("v%0d wr%0d addr_data", v, w), {15'd0, wr_addr[w], wr_data[w]},
                  {15'd0, 17'h100 + 17'(4 * w), vecs[v].c[w]});
        @(negedge clk);
        check($sformatf("v%0d idle_after", v), outs(), 64'd0);
    endtask

    initial begin
        int dn [0:3];
        int dn_cnt, late_busy, wr, any_out;

        for (int n = 0; n < 9; n++) begin
            vecs[0].a[n] = 32'(n + 1);
            vecs[0].b[n] = (n % 4 == 0) ? 32'd1 : 32'd0;
            vecs[0].c[n] = 32'(n + 1);
            vecs[1].a[n] = 32'(n + 1);
            vecs[1].b[n] = 32'(n + 1);
            vecs[2].a[n] = 32'hFFFF_FFFF;
            vecs[2].b[n] = 32'd2;
            vecs[2].c[n] = 32'hFFFF_FFFA;
            vecs[3].a[n] = 32'(n + 1);
            vecs[3].b[n] = 32'd1;
        end
        vecs[1].c = {32'd150, 32'd126, 32'd102, 32'd96, 32'd81, 32'd66, 32'd42, 32'd36, 32'd30};
        vecs[3].c = {32'd24, 32'd24, 32'd24, 32'd15, 32'd15, 32'd15, 32'd6, 32'd6, 32'd6};
        load(0);

        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_outputs", outs(), 64'd0);

        // Vector 1 also pulses start twice while busy; it must be ignored.
        for (int v = 0; v < 4; v++) run_vec(v, v == 1);

        // Held start: back-to-back runs with exactly one IDLE cycle between them.
        load(1);
        dn_cnt = 0; late_busy = 0; wr = 0;
        start = 1'b1;
        for (int n = 1; n <= 140; n++) begin
            @(negedge clk);
            if (n == 130) start = 1'b0;
            if (done && dn_cnt < 4) begin
                dn[dn_cnt] = n;
                dn_cnt++;
            end
            if (mem_write) wr++;
            if (n == 65) check("held_idle_gap", {62'd0, busy, done}, 64'd0);
            if (n >= 130 && busy) late_busy++;
        end
        check("held_done_count", 64'(dn_cnt), 64'd2);
        check("held_done0", 64'(dn[0]), 64'd64);
        check("held_done1", 64'(dn[1]), 64'd129);
        check("held_writes", 64'(wr), 64'd18);
        check("held_stops", 64'(late_busy), 64'd0);

        // Reset during RD_B at cycle 20 (element 3, k=2 -> B(2,2) at 0x320).
        wr = 0;
        start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (mem_write) wr++;
        end
        check("pre_reset_rd_b", {46'd0, mem_read, mem_addr}, {46'd0, 1'b1, 17'h320});
        check("pre_reset_writes", 64'(wr), 64'd2);
        reset = 1'b1;
        #1;
        check("reset_cycle_outputs", outs(), 64'd0);
        any_out = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) reset = 1'b0;
            if (outs() != 64'd0) any_out++;
        end
        check("post_reset_quiet", 64'(any_out), 64'd0);
        run_vec(1, 1'b0);

        // Reset and start together: reset wins.
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("reset_beats_start", outs(), 64'd0);

        check("read_write_overlap", 64'(overlap), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
